// File: rtl/bpa_pipelined_adder.sv
// Block-pipelined ripple adder: one M-bit block per stage, K = N/M stages.
// Define BPA_CIN_EN to add a stage-0 carry-in port Cin.
module bpa_pipelined_adder #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef BPA_CIN_EN
  input  logic         Cin,
`endif
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int K = N / M;

  generate
    if (M < 1 || M > N || (N % M) != 0) begin : g_bad
      $fatal(1, "bpa_pipelined_adder: N must be a multiple of M");
    end
  endgenerate

  logic cin0;

`ifdef BPA_CIN_EN
  assign cin0 = Cin;
`else
  assign cin0 = 1'b0;
`endif

  for (genvar k = 0; k < K; k++) begin : g_blk
    logic [M-1:0] a_in;
    logic [M-1:0] b_in;
    logic         c_in;
    logic [M:0]   tot;
    logic [M-1:0] s_q;
    logic         c_q;

    if (k == 0) begin : g_in
      assign a_in = A[M-1:0];
      assign b_in = B[M-1:0];
      assign c_in = cin0;
    end else begin : g_sk
      // Block k waits k edges so it meets the carry of its own pair
      logic [M-1:0] a_d [k];
      logic [M-1:0] b_d [k];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_d[i] <= '0;
            b_d[i] <= '0;
          end
        end else begin
          a_d[0] <= A[k*M +: M];
          b_d[0] <= B[k*M +: M];
          for (int i = 1; i < k; i++) begin
            a_d[i] <= a_d[i-1];
            b_d[i] <= b_d[i-1];
          end
        end
      end

      assign a_in = a_d[k-1];
      assign b_in = b_d[k-1];
      assign c_in = g_blk[k-1].c_q;
    end

    assign tot = {1'b0, a_in} + {1'b0, b_in}
               + {{M{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else begin
        s_q <= tot[M-1:0];
        c_q <= tot[M];
      end
    end

    if (k == K - 1) begin : g_top
      assign Sum[k*M +: M] = s_q;
    end else begin : g_dsk
      // Lower blocks finish early; hold them until the top block lands
      localparam int D = K - 1 - k;
      logic [M-1:0] d_q [D];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) d_q[i] <= '0;
        end else begin
          d_q[0] <= s_q;
          for (int i = 1; i < D; i++) d_q[i] <= d_q[i-1];
        end
      end

      assign Sum[k*M +: M] = d_q[D-1];
    end
  end

  assign Cout = g_blk[K-1].c_q;

endmodule

// File: tb/tb_bpa_pipelined_adder.sv
// Directed checks of the 16/4 adder plus random sweeps
// of 8/8, 16/1 and 32/8 configurations against a reference.
module tb_bpa_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] sum;
  logic        cout;

  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic [15:0] a1 = '0, b1 = '0, s1;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        c8, c1, c32;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bpa_pipelined_adder #(.N(16), .M(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef BPA_CIN_EN
    .Cin(cin),
`endif
    .A(a), .B(b), .Sum(sum), .Cout(cout)
  );

  bpa_pipelined_adder #(.N(8), .M(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
`ifdef BPA_CIN_EN
    .Cin(1'b0),
`endif
    .A(a8), .B(b8), .Sum(s8), .Cout(c8)
  );

  bpa_pipelined_adder #(.N(16), .M(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef BPA_CIN_EN
    .Cin(1'b0),
`endif
    .A(a1), .B(b1), .Sum(s1), .Cout(c1)
  );

  bpa_pipelined_adder #(.N(32), .M(8)) dut32 (
    .clk(clk), .rst_n(rst_n),
`ifdef BPA_CIN_EN
    .Cin(1'b0),
`endif
    .A(a32), .B(b32), .Sum(s32), .Cout(c32)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] x,
                       input logic [15:0] y);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect16(input string tag,
                          input logic [15:0] s,
                          input logic c);
    check(tag, {47'd0, cout, sum}, {47'd0, c, s});
  endtask

  logic [63:0] q8[$], q1[$], q32[$];

  initial begin
    // Reset held two edges
    drive(16'h1234, 16'h4321);
    drive(16'h1234, 16'h4321);
    expect16("reset", 16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(16'h0, 16'h0);
    expect16("post_reset_zero", 16'h0000, 1'b0);

    // Back-to-back stream
    drive(16'h00F8, 16'h0008);
    drive(16'd3, 16'd1);
    drive(16'd5, 16'd2);
    drive(16'd100, 16'd100);
    expect16("stream0", 16'h0100, 1'b0);
    drive(16'd100, 16'd100);
    expect16("stream1", 16'h0004, 1'b0);
    drive(16'd100, 16'd100);
    expect16("stream2", 16'h0007, 1'b0);
    drive(16'd100, 16'd100);
    expect16("stream3", 16'h00C8, 1'b0);
    drive(16'd100, 16'd100);
    expect16("hold", 16'h00C8, 1'b0);

    // Full ripple, no leak, max values
    drive(16'hFFFF, 16'h0001);
    drive(16'h0FFF, 16'h0001);
    drive(16'hFFFF, 16'hFFFF);
    drive(16'h0, 16'h0);
    expect16("ripple", 16'h0000, 1'b1);
    drive(16'h0, 16'h0);
    expect16("no_leak", 16'h1000, 1'b0);
    drive(16'h0, 16'h0);
    expect16("max", 16'hFFFE, 1'b1);
    drive(16'h0, 16'h0);
    expect16("drain", 16'h0000, 1'b0);

    // Reset mid-flight
    drive(16'd1, 16'd1);
    drive(16'd2, 16'd2);
    drive(16'd3, 16'd3);
    rst_n = 1'b0;
    drive(16'd7, 16'd7);
    expect16("mid_reset", 16'h0000, 1'b0);
    rst_n = 1'b1;
    drive(16'd9, 16'd9);
    expect16("flush0", 16'h0000, 1'b0);
    drive(16'h0, 16'h0);
    expect16("flush1", 16'h0000, 1'b0);
    drive(16'h0, 16'h0);
    expect16("flush2", 16'h0000, 1'b0);
    drive(16'h0, 16'h0);
    expect16("post_flush", 16'h0012, 1'b0);

`ifdef BPA_CIN_EN
    cin = 1'b1;
    drive(16'hFFFF, 16'h0000);
    cin = 1'b0;
    for (int i = 0; i < 3; i++) drive(16'h0, 16'h0);
    expect16("cin", 16'h0000, 1'b1);
`endif

    // Random sweep of other configurations
    rst_n = 1'b0;
    drive(16'h0, 16'h0);
    rst_n = 1'b1;
    q8 = {};
    q1 = {};
    q32 = {};
    for (int i = 0; i < 15; i++) q1.push_back(64'd0);
    for (int i = 0; i < 3; i++) q32.push_back(64'd0);
    for (int i = 0; i < 60; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      a1 = 16'($urandom);
      b1 = 16'($urandom);
      a32 = $urandom;
      b32 = $urandom;
      if (i % 10 == 3) begin
        a32 = 32'hFFFF_FFFF;
        b32 = 32'd1;
      end
      q8.push_back(64'({1'b0, a8} + {1'b0, b8}));
      q1.push_back(64'({1'b0, a1} + {1'b0, b1}));
      q32.push_back(64'({1'b0, a32} + {1'b0, b32}));
      @(posedge clk);
      #1;
      check("sweep_8_8", {55'd0, c8, s8}, q8.pop_front());
      check("sweep_16_1", {47'd0, c1, s1}, q1.pop_front());
      check("sweep_32_8", {31'd0, c32, s32}, q32.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/bpa_pipelined_adder.md
Name: bpa_pipelined_adder

Overview:
- N-bit block-pipelined ripple adder; operands split into K = N/M blocks of M bits.
- Each block is added in its own pipeline stage; the carry is registered between stages.
- Input-skew and output-deskew registers keep each result word aligned.
- Accepts a new operand pair every cycle; used as a high-throughput adder in datapaths where latency is tolerable.

Parameters:
- N, 16, operand and sum width in bits; must be a multiple of M.
- M, 4, block width in bits (bits added per stage); 1 <= M <= N.
- K (derived localparam, not overridable) = N/M, number of pipeline stages and the latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- A  input  N  operand A; sampled every rising edge.
- B  input  N  operand B; sampled every rising edge.
- Sum  output  N  registered (A+B) mod 2^N of the pair sampled K edges earlier.
- Cout  output  1  registered carry-out of the same addition.

Behaviour:
- Stage 0, each edge:
  - adds A[M-1:0] + B[M-1:0] + 0 (or Cin, see Optional Feature);
  - registers the M-bit partial sum and the carry;
  - registers the upper operand blocks 1..K-1 into skew registers.
- Stage k (1..K-1):
  - adds skewed block k of A and B plus the registered carry from stage k-1;
  - registers the M-bit result and the carry.
- Deskew: lower-block partial sums are delayed so that every block belonging to one operand pair reaches the output registers on the same edge.
- Sum and Cout are driven directly from flops; no combinational path from A/B to the outputs.
- Latency: operands sampled at edge t appear on Sum/Cout after edge t+K-1 (valid during cycle t+K-1..t+K). Default latency is 4 cycles.
- Throughput: one result per cycle; back-to-back operand pairs never interact.
- Arithmetic: unsigned; Sum = (A+B) mod 2^N; Cout = bit N of A+B. Signed overflow is not reported.
- Reset:
  - rst_n=0 at an edge clears every pipeline, skew, carry and output register to 0.
  - Sum=0 and Cout=0 from the following cycle.
  - Reset mid-operation discards all in-flight sums.
  - After rst_n returns to 1, the outputs show 0 + 0 results until the first post-reset operands emerge K edges later.
- M == N: K=1, single registered adder, latency 1.
- No valid/handshake signals; the consumer tracks latency K.
- Illegal configuration (N % M != 0) must be rejected at elaboration with a fatal message.

Optional Feature:
- Macro BPA_CIN_EN.
- Defined:
  - adds input port Cin (1 bit), sampled with A/B and used as the stage-0 carry-in;
  - Sum/Cout = A+B+Cin, with the same latency K;
  - Cin resets to no effect (its pipeline stage register is cleared like the others).
- Undefined: no Cin port; the stage-0 carry-in is constant 0.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> Sum=0x0000, Cout=0. Release, A=B=0 -> Sum stays 0.
- Back-to-back stream, one pair per 10 ns cycle: (0x00F8,0x0008), (3,1), (5,2), (100,100).
  - Sum sequence 0x0100, 0x0004, 0x0007, 0x00C8, each 4 cycles after its input; Cout=0.
  - Sum then holds 0x00C8 while inputs stay constant.
- Full carry ripple across all blocks: A=0xFFFF, B=0x0001 -> Sum=0x0000, Cout=1 after 4 cycles.
  - In the same stream, A=0x0FFF, B=0x0001 on the next cycle -> Sum=0x1000, Cout=0 the following cycle (no carry leak between pairs).
- Maximum values: A=0xFFFF, B=0xFFFF -> Sum=0xFFFE, Cout=1.
- Reset mid-flight: issue 3 pairs, assert rst_n=0 for one edge -> no pre-reset result ever appears; outputs are 0 until post-reset data emerges.
- Parameter sweep: N=8, M=8 (latency 1), N=16, M=1 (latency 16) and N=32, M=8 against a reference model on random streams.
  - With BPA_CIN_EN: A=0xFFFF, B=0, Cin=1 -> Sum=0, Cout=1.
